serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 115 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one shared full adder processes a WIDTH-bit
// operation LSB first, one bit per clock, behind a start/busy/done handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c_r;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH:0]   s_cat;
  logic [WIDTH-1:0] s_next;
  logic             last_bit;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (c_r),
    .s  (fa_s),
    .co (fa_co)
  );

  // Concatenate-then-slice keeps the sum shift legal even when WIDTH is 1.
  assign s_cat    = {fa_s, s_sh};
  assign s_next   = s_cat[WIDTH:1];
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every flop in
  // this block samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c_r   <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= sub ? ~B : B;
            c_r   <= sub ? 1'b1 : Cin;
            s_sh  <= '0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= s_next;
          c_r  <= fa_co;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            // c_r here is the carry into the MSB; fa_co is the carry out of it.
            Sum   <= s_next;
            Cout  <= fa_co;
            Ovf   <= c_r ^ fa_co;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH 8, 1 and 16 against an
// arithmetic reference model.

module tb_serial_adder_ctrl;

  logic clk;
  logic rst;

  logic        st8, sb8, ci8, busy8, done8, co8, ov8;
  logic [7:0]  a8, b8, s8;
  logic        st1, sb1, ci1, busy1, done1, co1, ov1;
  logic [0:0]  a1, b1, s1;
  logic        st16, sb16, ci16, busy16, done16, co16, ov16;
  logic [15:0] a16, b16, s16;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sb8), .A(a8), .B(b8), .Cin(ci8),
    .busy(busy8), .done(done8), .Sum(s8), .Cout(co8), .Ovf(ov8)
  );
  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st1), .sub(sb1), .A(a1), .B(b1), .Cin(ci1),
    .busy(busy1), .done(done1), .Sum(s1), .Cout(co1), .Ovf(ov1)
  );
  serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(st16), .sub(sb16), .A(a16), .B(b16), .Cin(ci16),
    .busy(busy16), .done(done16), .Sum(s16), .Cout(co16), .Ovf(ov16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wid(input int inst);
    return (inst == 0) ? 8 : (inst == 1) ? 1 : 16;
  endfunction

  // Reference: modulo-2^w addition of A and the effective B, signed overflow by sign rule.
  function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic sb, input logic ci,
                                     output logic [31:0] s, output logic co, output logic ov);
    logic [63:0] mask, beff, full, am;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, a} & mask;
    beff = sb ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
    full = am + beff + (sb ? 64'd1 : {63'd0, ci});
    s    = 32'(full & mask);
    co   = full[w];
    ov   = (am[w-1] == beff[w-1]) && (s[w-1] != am[w-1]);
  endfunction

  task automatic set_in(input int inst, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input logic sb, input logic ci);
    case (inst)
      0:       begin st8  = st; a8  = a[7:0];  b8  = b[7:0];  sb8  = sb; ci8  = ci; end
      1:       begin st1  = st; a1  = a[0:0];  b1  = b[0:0];  sb1  = sb; ci1  = ci; end
      default: begin st16 = st; a16 = a[15:0]; b16 = b[15:0]; sb16 = sb; ci16 = ci; end
    endcase
  endtask

  task automatic set_start(input int inst, input logic st);
    case (inst)
      0:       st8  = st;
      1:       st1  = st;
      default: st16 = st;
    endcase
  endtask

  function automatic void read_out(input int inst, output logic bz, output logic dn,
                                   output logic [31:0] s, output logic co, output logic ov);
    case (inst)
      0:       begin bz = busy8;  dn = done8;  s = {24'd0, s8};  co = co8;  ov = ov8;  end
      1:       begin bz = busy1;  dn = done1;  s = {31'd0, s1};  co = co1;  ov = ov1;  end
      default: begin bz = busy16; dn = done16; s = {16'd0, s16}; co = co16; ov = ov16; end
    endcase
  endfunction

  // Issues at the current (negedge) time, waits for done; returns at the done negedge.
  task automatic do_op(input int inst, input logic [31:0] a, input logic [31:0] b,
                       input logic sb, input logic ci, input bit hold, output time t_done);
    logic [31:0] es, s;
    logic        eco, eov, bz, dn, co, ov;
    int          n;
    bit          found;
    int          w;
    w = wid(inst);
    ref_model(w, a, b, sb, ci, es, eco, eov);
    set_in(inst, 1'b1, a, b, sb, ci);
    @(posedge clk);
    #1;
    // Scramble operands after the start edge; optionally keep start asserted.
    set_in(inst, hold, $urandom, $urandom, 1'($urandom), 1'($urandom));
    n = 0;
    found = 0;
    t_done = 0;
    repeat (w + 4) begin
      @(negedge clk);
      read_out(inst, bz, dn, s, co, ov);
      if (dn) begin
        found = 1;
        break;
      end
      check($sformatf("busy[%0d]", inst), {63'd0, bz}, 64'd1);
      n++;
    end
    set_start(inst, 1'b0);
    if (!found) begin
      check($sformatf("timeout[%0d]", inst), 64'd0, 64'd1);
    end else begin
      t_done = $time;
      check($sformatf("latency[%0d]", inst), 64'(n), 64'(w));
      check($sformatf("busy_at_done[%0d]", inst), {63'd0, bz}, 64'd0);
      check($sformatf("sum[%0d] a=%0h b=%0h sub=%0b", inst, a, b, sb), {32'd0, s}, {32'd0, es});
      check($sformatf("cout[%0d]", inst), {63'd0, co}, {63'd0, eco});
      check($sformatf("ovf[%0d]", inst), {63'd0, ov}, {63'd0, eov});
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] s;
      logic bz, dn, co, ov;
      read_out(i, bz, dn, s, co, ov);
      check($sformatf("%s_busy[%0d]", tag, i), {63'd0, bz}, 64'd0);
      check($sformatf("%s_done[%0d]", tag, i), {63'd0, dn}, 64'd0);
      check($sformatf("%s_sum[%0d]", tag, i), {32'd0, s}, 64'd0);
      check($sformatf("%s_cout[%0d]", tag, i), {63'd0, co}, 64'd0);
      check($sformatf("%s_ovf[%0d]", tag, i), {63'd0, ov}, 64'd0);
    end
  endtask

  initial begin
    time t1, t2;
    logic [31:0] s, s_hold;
    logic bz, dn, co, ov;
    int n_done;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8 vectors.
    do_op(0, 32'h3C, 32'h05, 1'b0, 1'b0, 0, t1);
    do_op(0, 32'hFF, 32'h01, 1'b0, 1'b0, 0, t1);
    do_op(0, 32'h7F, 32'h01, 1'b0, 1'b0, 0, t1);
    do_op(0, 32'h10, 32'h20, 1'b1, 1'b1, 0, t1);
    do_op(0, 32'h80, 32'h01, 1'b1, 1'b0, 0, t1);

    // start held with fresh operands during RUN, then back-to-back issue in DONE.
    do_op(0, 32'h55, 32'h22, 1'b0, 1'b1, 1, t1);
    do_op(0, 32'h01, 32'h02, 1'b0, 1'b0, 0, t2);
    check("b2b_interval", 64'(t2 - t1), 64'd90);

    // Result holds while idle.
    read_out(0, bz, dn, s_hold, co, ov);
    repeat (5) begin
      @(negedge clk);
      read_out(0, bz, dn, s, co, ov);
      check("hold_sum", {32'd0, s}, {32'd0, s_hold});
      check("hold_done", {63'd0, dn}, 64'd0);
    end

    // Asynchronous reset three cycles into RUN.
    set_in(0, 1'b1, 32'h33, 32'h44, 1'b0, 1'b0);
    @(posedge clk);
    #1 set_start(0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_outputs_zero("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      read_out(0, bz, dn, s, co, ov);
      if (dn) n_done++;
    end
    check("no_done_after_abort", 64'(n_done), 64'd0);
    do_op(0, 32'h0A, 32'h0B, 1'b0, 1'b0, 0, t1);

    // WIDTH=1 corner.
    do_op(1, 32'h1, 32'h1, 1'b0, 1'b1, 0, t1);
    do_op(1, 32'h0, 32'h0, 1'b0, 1'b1, 0, t1);
    do_op(1, 32'h1, 32'h0, 1'b1, 1'b0, 0, t1);

    // WIDTH=16 random sweep, mixing idle gaps, back-to-back and held start.
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_op(2, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), t1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
